// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-pass shifter: FSM states, direction and fill selects.
package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic FILL_ZERO = 1'b0;
   localparam logic FILL_EDGE = 1'b1;

endpackage

// File: rtl/shift_sequencer_step.sv
// Single combinational shift pass of 0..3 positions; vacated bits take zero or the
// edge bit (MSB for right shifts, LSB for left shifts).
module shift_step
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   input  logic             dir,
   input  logic             fill,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] result
);

   logic        fill_bit;
   int unsigned sh;

   always_comb begin
      sh       = {30'd0, s};
      fill_bit = (fill == FILL_EDGE) && ((dir == DIR_LEFT) ? data[0] : data[WIDTH-1]);
      result   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (dir == DIR_LEFT)
            result[i] = (i >= sh) ? data[i - sh] : fill_bit;
         else
            result[i] = (i + sh < WIDTH) ? data[i + sh] : fill_bit;
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: accepts a command, iterates shift_step until the
// clamped distance is consumed, then holds the result until it is taken.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned AMT_W    = 4,
   parameter int unsigned MAX_STEP = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic             cmd_fill,
   input  logic [AMT_W-1:0] cmd_amt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q;
   logic             dir_q;
   logic             fill_q;
   logic [AMT_W-1:0] rem_q;
   logic [AMT_W-1:0] amt_clamp;
   logic [AMT_W-1:0] step;
   logic [WIDTH-1:0] stage_out;
   logic             accept;

   // Clamping at WIDTH gives the all-fill result and bounds latency.
   assign amt_clamp = (cmd_amt > AMT_W'(WIDTH))    ? AMT_W'(WIDTH)    : cmd_amt;
   assign step      = (rem_q   > AMT_W'(MAX_STEP)) ? AMT_W'(MAX_STEP) : rem_q;

   assign cmd_ready = (state == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign res_valid = (state == DONE);
   assign res_data  = data_q;
   assign busy      = (state == RUN) || (state == DONE);

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data   (data_q),
      .dir    (dir_q),
      .fill   (fill_q),
      .s      (step[1:0]),
      .result (stage_out)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = (amt_clamp == '0) ? DONE : RUN;
         RUN:  if (rem_q == step) state_nxt = DONE;
         DONE: if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         data_q <= '0;
         dir_q  <= DIR_RIGHT;
         fill_q <= FILL_ZERO;
         rem_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept) begin
            data_q <= cmd_data;
            dir_q  <= cmd_dir;
            fill_q <= cmd_fill;
            rem_q  <= amt_clamp;
         end else if (state == RUN) begin
            data_q <= stage_out;
            rem_q  <= rem_q - step;
         end
      end
   end

endmodule
